matrix_number_scan: RTL

- Display back-end that consumes the flat `matrixData` (128 b) and `numbersData` (32 b) buses produced by the content modules (self-test, game logic).
- Drives the physical 8x8 red/green LED matrix and the 8-digit seven-segment display by time-multiplexed scanning.
- Sits between the content muxing logic and the board pins.
- One scan index is shared by matrix rows and seven-segment digits.

---
 rtl/matrix_number_scan_pkg.sv | 32 +++
 rtl/matrix_number_scan_if.sv | 30 +++
 rtl/seg_decode.sv | 29 ++
 rtl/matrix_number_scan.sv | 99 +++++++++
 4 files changed

// File: rtl/matrix_number_scan_pkg.sv
// rtl/matrix_number_scan_pkg.sv - shared segment patterns, blank-digit code and pixel colours
package matrix_number_scan_pkg;

    // Active-high {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h00;

    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    // Two bits per pixel in matrixData: {red, green}
    typedef enum logic [1:0] {
        OFF    = 2'b00,
        GREEN  = 2'b01,
        RED    = 2'b10,
        YELLOW = 2'b11
    } pix_color_e;

endpackage

// File: rtl/matrix_number_scan_if.sv
// rtl/matrix_number_scan_if.sv - content-in / pins-out bundle; dim port exists only with SCAN_DIM_EN
interface matrix_number_scan_if;
    logic [127:0] matrixData;
    logic [31:0]  numbersData;
`ifdef SCAN_DIM_EN
    logic [2:0]   dim;
`endif
    logic [7:0]   row_n;
    logic [7:0]   col_r;
    logic [7:0]   col_g;
    logic [7:0]   dig_n;
    logic [7:0]   seg;
    logic         frame_start;

    modport master (
        output matrixData, numbersData,
`ifdef SCAN_DIM_EN
        output dim,
`endif
        input  row_n, col_r, col_g, dig_n, seg, frame_start
    );

    modport slave (
        input  matrixData, numbersData,
`ifdef SCAN_DIM_EN
        input  dim,
`endif
        output row_n, col_r, col_g, dig_n, seg, frame_start
    );
endinterface

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - combinational hex digit to seven-segment pattern; code F is blank
module seg_decode
    import matrix_number_scan_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = SEG_F;
        case (digit_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            default: seg_o = SEG_F;
        endcase
    end
endmodule

// File: rtl/matrix_number_scan.sv
// rtl/matrix_number_scan.sv - 8x8 LED matrix + 8-digit scanner; SCAN_DIM_EN adds frame-sampled dimming
module matrix_number_scan
    import matrix_number_scan_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 50
) (
    input  logic                 clk,
    input  logic                 sw,
    matrix_number_scan_if.slave  bus
);
    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0]  div_cnt_q;
    logic [2:0]     idx_q;
    logic [127:0]   mat_snap_q;
    logic [31:0]    num_snap_q;
    logic [2:0]     dim_q;
    logic [2:0]     dim_d;
    logic [7:0]     row_n_q, col_r_q, col_g_q, dig_n_q, seg_q;
    logic           frame_start_q;

    logic           snap_now;
    logic           div_wrap;
    logic           lit;
    logic [31:0]    lit_off;
    logic [15:0]    row_bits;
    logic [7:0]     col_r_d, col_g_d, sel_n_d;
    logic [6:0]     seg7;

    assign snap_now = (idx_q == 3'd0) && (div_cnt_q == '0);
    assign div_wrap = (div_cnt_q == CW'(SCAN_DIV - 1));
    assign lit_off  = 32'(div_cnt_q) - 32'(BLANK_CYCLES);

`ifdef SCAN_DIM_EN
    assign dim_d = bus.dim;
`else
    assign dim_d = 3'd7;
`endif

    // Lit window after the dead time, shortened to (dim+1)/8 of it when dimming
    assign lit = (32'(div_cnt_q) >= 32'(BLANK_CYCLES)) &&
                 ((lit_off << 3) < ((32'(dim_q) + 32'd1) * 32'(SCAN_DIV - BLANK_CYCLES)));

    assign row_bits = mat_snap_q[{idx_q, 4'b0000} +: 16];
    assign sel_n_d  = ~(8'd1 << idx_q);

    always_comb begin
        col_r_d = '0;
        col_g_d = '0;
        for (int c = 0; c < 8; c++) begin
            col_r_d[c] = row_bits[2*c+1];
            col_g_d[c] = row_bits[2*c];
        end
    end

    seg_decode u_seg_decode (
        .digit_i (num_snap_q[{idx_q, 2'b00} +: 4]),
        .seg_o   (seg7)
    );

    always_ff @(posedge clk or negedge sw) begin
        if (!sw) begin
            div_cnt_q     <= '0;
            idx_q         <= '0;
            mat_snap_q    <= '0;
            num_snap_q    <= {8{BLANK_DIGIT}};
            dim_q         <= 3'd7;
            row_n_q       <= 8'hFF;
            dig_n_q       <= 8'hFF;
            col_r_q       <= '0;
            col_g_q       <= '0;
            seg_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q <= div_wrap ? '0 : div_cnt_q + 1'b1;
            if (div_wrap)
                idx_q <= idx_q + 3'd1;
            if (snap_now) begin
                mat_snap_q <= bus.matrixData;
                num_snap_q <= bus.numbersData;
                dim_q      <= dim_d;
            end
            frame_start_q <= snap_now;
            row_n_q <= lit ? sel_n_d : 8'hFF;
            dig_n_q <= lit ? sel_n_d : 8'hFF;
            col_r_q <= lit ? col_r_d : 8'h00;
            col_g_q <= lit ? col_g_d : 8'h00;
            seg_q   <= lit ? {1'b0, seg7} : 8'h00;
        end
    end

    assign bus.row_n       = row_n_q;
    assign bus.dig_n       = dig_n_q;
    assign bus.col_r       = col_r_q;
    assign bus.col_g       = col_g_q;
    assign bus.seg         = seg_q;
    assign bus.frame_start = frame_start_q;
endmodule
